lane_demand_encoder: RTL and testbench

//  Upstream stage of the 4-way traffic controller. Turns raw per-lane vehicle detector levels into
//  the 2-bit demand levels Sa..Sd that the controller compares. Per lane it synchronises, debounces
//  and edge-detects arrival and departure detectors. It keeps a saturating queue count and quantises

---
 rtl/lane_demand_encoder.sv | 112 +++++++++++
 tb/tb_lane_demand_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_demand_encoder.sv
// Per-lane vehicle demand encoder: synchronises, debounces and edge-detects arrival/departure
// detectors, keeps a saturating queue count per lane and quantises it to a 2-bit demand level.
module lane_demand_encoder #(
  parameter int unsigned QW  = 6,
  parameter int unsigned DEB = 3,
  parameter int unsigned TH1 = 4,
  parameter int unsigned TH2 = 12,
  parameter int unsigned TH3 = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      arr,
  input  logic [3:0]      dep,
  output logic [1:0]      Sa,
  output logic [1:0]      Sb,
  output logic [1:0]      Sc,
  output logic [1:0]      Sd,
  output logic [4*QW-1:0] q_count,
  output logic [3:0]      q_ovf
);

  localparam int unsigned NCH   = 8;
  localparam int unsigned NLANE = 4;
  localparam int unsigned DCW   = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [QW-1:0] QMAX = {QW{1'b1}};

  // channels 0..3 are arrivals A..D, channels 4..7 are departures A..D
  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] filt;
  logic [NCH-1:0] ev;
  logic [DCW-1:0] dcnt [NCH];
  logic [QW-1:0]  q    [NLANE];
  logic [1:0]     lvl  [NLANE];

  assign raw = {dep, arr};

  function automatic logic [1:0] quantise(input logic [QW-1:0] c);
    if (c < QW'(TH1))      return 2'd0;
    else if (c < QW'(TH2)) return 2'd1;
    else if (c < QW'(TH3)) return 2'd2;
    else                   return 2'd3;
  endfunction

  always_ff @(posedge clk or posedge rst) begin : sync
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // A level is accepted after DEB consecutive mismatching samples; ev marks accepted rises only
  always_ff @(posedge clk or posedge rst) begin : debounce
    if (rst) begin
      filt <= '0;
      ev   <= '0;
      for (int i = 0; i < NCH; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ev[i] <= 1'b0;
        if (s2[i] == filt[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] < DCW'(DEB - 1)) begin
          dcnt[i] <= dcnt[i] + DCW'(1);
        end else begin
          filt[i] <= s2[i];
          dcnt[i] <= '0;
          ev[i]   <= s2[i];
        end
      end
    end
  end

  // Saturating queue; simultaneous arrival and departure cancel out
  always_ff @(posedge clk or posedge rst) begin : queue
    if (rst) begin
      q_ovf <= '0;
      for (int i = 0; i < NLANE; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < NLANE; i++) begin
        if (ev[i] && !ev[i+4]) begin
          if (q[i] == QMAX) q_ovf[i] <= 1'b1;
          else              q[i]     <= q[i] + QW'(1);
        end else if (ev[i+4] && !ev[i]) begin
          if (q[i] != '0) q[i] <= q[i] - QW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : quant
    if (rst) begin
      for (int i = 0; i < NLANE; i++) lvl[i] <= '0;
    end else begin
      for (int i = 0; i < NLANE; i++) lvl[i] <= quantise(q[i]);
    end
  end

  for (genvar g = 0; g < NLANE; g++) begin : g_cnt
    assign q_count[g*QW +: QW] = q[g];
  end

  assign Sa = lvl[0];
  assign Sb = lvl[1];
  assign Sc = lvl[2];
  assign Sd = lvl[3];

endmodule

// File: tb/tb_lane_demand_encoder.sv
// Bench for lane_demand_encoder: directed scenario tasks plus randomized detector levels
// checked cycle by cycle against a run-length behavioural model.
module tb_lane_demand_encoder;

  localparam int QW   = 6;
  localparam int DEB  = 3;
  localparam int TH1  = 4;
  localparam int TH2  = 12;
  localparam int TH3  = 24;
  localparam int QMAX = (1 << QW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [3:0]      arr = '0;
  logic [3:0]      dep = '0;
  logic [1:0]      sa, sb, sc, sd;
  logic [4*QW-1:0] q_count;
  logic [3:0]      q_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  lane_demand_encoder #(.QW(QW), .DEB(DEB), .TH1(TH1), .TH2(TH2), .TH3(TH3)) dut (
    .clk(clk), .rst(rst), .arr(arr), .dep(dep),
    .Sa(sa), .Sb(sb), .Sc(sc), .Sd(sd),
    .q_count(q_count), .q_ovf(q_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural model: a level is accepted once it has differed from the accepted
  // level for DEB consecutive synchronised samples; counts move on accepted rises.
  int m_s1 [8];
  int m_s2 [8];
  int m_run [8];
  int m_filt [8];
  int m_ev [8];
  int m_q [4];
  int m_ovf [4];
  int m_lvl [4];

  function automatic int level_of(input int c);
    if (c >= TH3) return 3;
    if (c >= TH2) return 2;
    if (c >= TH1) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 8; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_run[c] = 0; m_filt[c] = 0; m_ev[c] = 0;
      end
      for (int l = 0; l < 4; l++) begin
        m_q[l] = 0; m_ovf[l] = 0; m_lvl[l] = 0;
      end
    end else begin
      for (int l = 0; l < 4; l++) m_lvl[l] = level_of(m_q[l]);
      for (int l = 0; l < 4; l++) begin
        if (m_ev[l] == 1 && m_ev[l+4] == 0) begin
          if (m_q[l] == QMAX) m_ovf[l] = 1;
          else m_q[l] = m_q[l] + 1;
        end else if (m_ev[l+4] == 1 && m_ev[l] == 0 && m_q[l] > 0) begin
          m_q[l] = m_q[l] - 1;
        end
      end
      for (int c = 0; c < 8; c++) begin
        m_ev[c] = 0;
        if (m_s2[c] != m_filt[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DEB) begin
            m_filt[c] = m_s2[c];
            m_run[c]  = 0;
            m_ev[c]   = m_filt[c];
          end
        end else begin
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = (c < 4) ? int'(arr[c]) : int'(dep[c-4]);
      end
    end
  end

  function automatic int cnt(input int lane);
    return int'(q_count[lane*QW +: QW]);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; arr = '0; dep = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One clean detector event per set bit: held long enough to pass debounce, then released
  task automatic arrive(input logic [3:0] am, input logic [3:0] dm);
    arr = am; dep = dm;
    repeat (5) @(negedge clk);
    arr = '0; dep = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; arr = 4'hF; dep = 4'hF;
    repeat (4) @(negedge clk);
    n_checks++;
    if (q_count !== '0 || q_ovf !== 4'h0 || {sa, sb, sc, sd} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_hold: q_count=%h q_ovf=%h S=%h required all 0", q_count, q_ovf, {sa, sb, sc, sd});
    end
    arr = 4'h1; dep = 4'h0;
    rst = 1'b0;
    // edges 0..4 after release: count still 0
    repeat (5) @(negedge clk);
    n_checks++;
    if (cnt(0) !== 0) begin
      n_fail++;
      $display("FAIL reset_release_early: countA=%0d required 0 at edge DEB+1", cnt(0));
    end
    @(negedge clk);
    n_checks++;
    if (cnt(0) !== 1) begin
      n_fail++;
      $display("FAIL reset_release_arrival: countA=%0d required 1 at edge DEB+2", cnt(0));
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (cnt(0) !== 1) begin
      n_fail++;
      $display("FAIL reset_held_level: countA=%0d required 1 (one event per level)", cnt(0));
    end
    arr = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_debounce();
    do_reset();
    arr = 4'h2;
    repeat (2) @(negedge clk);
    arr = '0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (cnt(1) !== 0) begin
      n_fail++;
      $display("FAIL debounce_short: countB=%0d required 0", cnt(1));
    end
    arr = 4'h2;
    repeat (4) @(negedge clk);
    arr = '0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (cnt(1) !== 1) begin
      n_fail++;
      $display("FAIL debounce_accept: countB=%0d required 1", cnt(1));
    end
  endtask

  task automatic test_thresholds();
    int budget;
    do_reset();
    repeat (3) arrive(4'h4, 4'h0);
    n_checks++;
    if (cnt(2) !== 3 || sc !== 2'd0) begin
      n_fail++;
      $display("FAIL thr_below: countC=%0d Sc=%0d required 3/0", cnt(2), sc);
    end
    arr = 4'h4;
    budget = 0;
    while (cnt(2) != 4 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (cnt(2) !== 4 || sc !== 2'd0) begin
      n_fail++;
      $display("FAIL thr_edge_count: countC=%0d Sc=%0d required 4/0 on count update", cnt(2), sc);
    end
    @(negedge clk);
    n_checks++;
    if (sc !== 2'd1) begin
      n_fail++;
      $display("FAIL thr_level1_latency: Sc=%0d required 1 one cycle after count 4", sc);
    end
    arr = '0;
    repeat (5) @(negedge clk);
    repeat (8) arrive(4'h4, 4'h0);
    n_checks++;
    if (cnt(2) !== 12 || sc !== 2'd2) begin
      n_fail++;
      $display("FAIL thr_level2: countC=%0d Sc=%0d required 12/2", cnt(2), sc);
    end
    repeat (12) arrive(4'h4, 4'h0);
    n_checks++;
    if (cnt(2) !== 24 || sc !== 2'd3) begin
      n_fail++;
      $display("FAIL thr_level3: countC=%0d Sc=%0d required 24/3", cnt(2), sc);
    end
    arrive(4'h0, 4'h4);
    n_checks++;
    if (cnt(2) !== 23 || sc !== 2'd2) begin
      n_fail++;
      $display("FAIL thr_depart: countC=%0d Sc=%0d required 23/2", cnt(2), sc);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (70) arrive(4'h8, 4'h0);
    n_checks++;
    if (cnt(3) !== QMAX || q_ovf[3] !== 1'b1 || sd !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_lane_d: countD=%0d ovf=%b Sd=%0d required %0d/1/3", cnt(3), q_ovf[3], sd, QMAX);
    end
    repeat (3) arrive(4'h0, 4'h1);
    n_checks++;
    if (cnt(0) !== 0 || q_ovf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_lane_a: countA=%0d ovf=%b required 0/0", cnt(0), q_ovf[0]);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    arrive(4'h2, 4'h2);
    n_checks++;
    if (cnt(1) !== 0) begin
      n_fail++;
      $display("FAIL simul_zero: countB=%0d required 0", cnt(1));
    end
    repeat (5) arrive(4'h2, 4'h0);
    arrive(4'h2, 4'h2);
    n_checks++;
    if (cnt(1) !== 5) begin
      n_fail++;
      $display("FAIL simul_five: countB=%0d required 5", cnt(1));
    end
    repeat (QMAX - 5) arrive(4'h2, 4'h0);
    arrive(4'h2, 4'h2);
    n_checks++;
    if (cnt(1) !== QMAX || q_ovf[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_max: countB=%0d ovf=%b required %0d/0", cnt(1), q_ovf[1], QMAX);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] m;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      m = {k < 40, k < 30, k < 20, k < 10};
      arrive(m, 4'h0);
    end
    n_checks++;
    if (cnt(0) !== 10 || cnt(1) !== 20 || cnt(2) !== 30 || cnt(3) !== 40) begin
      n_fail++;
      $display("FAIL midrst_setup: counts=%0d/%0d/%0d/%0d required 10/20/30/40", cnt(0), cnt(1), cnt(2), cnt(3));
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (q_count !== '0 || q_ovf !== 4'h0 || {sa, sb, sc, sd} !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_async: q_count=%h q_ovf=%h S=%h required all 0", q_count, q_ovf, {sa, sb, sc, sd});
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (2) arrive(4'h1, 4'h0);
    n_checks++;
    if (cnt(0) !== 2 || cnt(1) !== 0) begin
      n_fail++;
      $display("FAIL midrst_resume: countA=%0d countB=%0d required 2/0", cnt(0), cnt(1));
    end
  endtask

  task automatic test_random();
    logic [7:0] lv;
    int exp_q;
    do_reset();
    lv = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(3) == 0) lv[b] = ~lv[b];
      arr = lv[3:0];
      dep = lv[7:4];
      @(negedge clk);
      for (int l = 0; l < 4; l++) begin
        exp_q = m_q[l];
        n_checks++;
        if (cnt(l) !== exp_q || int'(q_ovf[l]) !== m_ovf[l]) begin
          n_fail++;
          $display("FAIL rand_count lane%0d cyc%0d: count=%0d ovf=%b required %0d/%0d", l, cyc, cnt(l), q_ovf[l], exp_q, m_ovf[l]);
        end
      end
      n_checks++;
      if (int'(sa) !== m_lvl[0] || int'(sb) !== m_lvl[1] || int'(sc) !== m_lvl[2] || int'(sd) !== m_lvl[3]) begin
        n_fail++;
        $display("FAIL rand_level cyc%0d: S=%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", cyc, sa, sb, sc, sd,
                 m_lvl[0], m_lvl[1], m_lvl[2], m_lvl[3]);
      end
    end
    arr = '0; dep = '0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_thresholds();
    test_saturation();
    test_simultaneous();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
